// File: rtl/pipe_stage_reg_pkg.sv
// Shared pipeline stage constants: payload layouts,
// bubble patterns and skid buffer state encodings.
package pipe_stage_reg_pkg;

  localparam int unsigned PC_W   = 32;
  localparam int unsigned INSN_W = 32;
  localparam int unsigned ALU_W  = 32;
  localparam int unsigned WE_W   = 1;
  localparam int unsigned DST_W  = 5;
  localparam int unsigned MEM_W  = 32;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  // IF/ID: {insn, pc}
  localparam int unsigned IF_ID_PC_OFF   = 0;
  localparam int unsigned IF_ID_INSN_OFF = 32;
  localparam int unsigned IF_ID_W        = 64;

  // ID/EX: {dst, gpr_we_, insn, pc}
  localparam int unsigned ID_EX_PC_OFF   = 0;
  localparam int unsigned ID_EX_INSN_OFF = 32;
  localparam int unsigned ID_EX_WE_OFF   = 64;
  localparam int unsigned ID_EX_DST_OFF  = 65;
  localparam int unsigned ID_EX_W        = 70;

  // EX/MEM: {mem_data, dst, gpr_we_, alu_out, pc}
  localparam int unsigned EX_MEM_PC_OFF  = 0;
  localparam int unsigned EX_MEM_ALU_OFF = 32;
  localparam int unsigned EX_MEM_WE_OFF  = 64;
  localparam int unsigned EX_MEM_DST_OFF = 65;
  localparam int unsigned EX_MEM_MEM_OFF = 70;
  localparam int unsigned EX_MEM_W       = 102;

  // MEM/WB: {mem_data, dst, gpr_we_, alu_out}
  localparam int unsigned MEM_WB_ALU_OFF = 0;
  localparam int unsigned MEM_WB_WE_OFF  = 32;
  localparam int unsigned MEM_WB_DST_OFF = 33;
  localparam int unsigned MEM_WB_MEM_OFF = 38;
  localparam int unsigned MEM_WB_W       = 70;

  // Bubbles keep the active-low gpr_we_ high so they never write.
  localparam logic [IF_ID_W-1:0] IF_ID_BUBBLE =
    {NOP_INSN, 32'h0};
  localparam logic [ID_EX_W-1:0] ID_EX_BUBBLE =
    ID_EX_W'(1) << ID_EX_WE_OFF;
  localparam logic [EX_MEM_W-1:0] EX_MEM_BUBBLE =
    EX_MEM_W'(1) << EX_MEM_WE_OFF;
  localparam logic [MEM_WB_W-1:0] MEM_WB_BUBBLE =
    MEM_WB_W'(1) << MEM_WB_WE_OFF;

  // {skid_v, main_v}
  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_BUSY  = 2'b01;
  localparam logic [1:0] ST_FULL  = 2'b11;

endpackage

// File: rtl/pipe_stage_reg_cnt_sat.sv
// Saturating up-counter with enable, used for
// stall-cycle performance monitoring.
module pipe_stage_cnt_sat #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i && (cnt_q != '1)) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic valid/ready pipeline stage register with
// flush, optional skid entry and stall counter.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int unsigned           PAYLOAD_W  = 128,
  parameter bit                    SKID       = 1'b1,
  parameter logic [PAYLOAD_W-1:0]  BUBBLE_VAL = '0,
  parameter int unsigned           CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_data,
  input  logic                 flush,
  output logic [CNT_W-1:0]     stall_cnt
);

  logic                 main_v_q, main_v_d;
  logic [PAYLOAD_W-1:0] main_q, main_d;
  logic                 accept, deliver;

  assign accept  = in_valid && in_ready;
  assign deliver = main_v_q && out_ready;

  if (SKID) begin : g_skid
    logic                 skid_v_q, skid_v_d;
    logic [PAYLOAD_W-1:0] skid_q, skid_d;

    assign in_ready = !skid_v_q;

    always_comb begin
      main_v_d = main_v_q;
      main_d   = main_q;
      skid_v_d = skid_v_q;
      skid_d   = skid_q;
      if (flush) begin
        main_v_d = 1'b0;
        main_d   = BUBBLE_VAL;
        skid_v_d = 1'b0;
        skid_d   = BUBBLE_VAL;
      end else begin
        case ({skid_v_q, main_v_q})
          ST_EMPTY: begin
            if (accept) begin
              main_v_d = 1'b1;
              main_d   = in_data;
            end
          end
          ST_BUSY: begin
            if (accept && deliver) begin
              main_d = in_data;
            end else if (accept) begin
              skid_v_d = 1'b1;
              skid_d   = in_data;
            end else if (deliver) begin
              main_v_d = 1'b0;
              main_d   = BUBBLE_VAL;
            end
          end
          ST_FULL: begin
            if (deliver) begin
              main_d   = skid_q;
              skid_v_d = 1'b0;
              skid_d   = BUBBLE_VAL;
            end
          end
          default: begin
            main_v_d = 1'b0;
            main_d   = BUBBLE_VAL;
            skid_v_d = 1'b0;
            skid_d   = BUBBLE_VAL;
          end
        endcase
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        skid_v_q <= 1'b0;
        skid_q   <= BUBBLE_VAL;
      end else begin
        skid_v_q <= skid_v_d;
        skid_q   <= skid_d;
      end
    end
  end else begin : g_noskid
    assign in_ready = out_ready || !main_v_q;

    always_comb begin
      main_v_d = main_v_q;
      main_d   = main_q;
      if (flush) begin
        main_v_d = 1'b0;
        main_d   = BUBBLE_VAL;
      end else if (accept) begin
        main_v_d = 1'b1;
        main_d   = in_data;
      end else if (deliver) begin
        main_v_d = 1'b0;
        main_d   = BUBBLE_VAL;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_v_q <= 1'b0;
      main_q   <= BUBBLE_VAL;
    end else begin
      main_v_q <= main_v_d;
      main_q   <= main_d;
    end
  end

  assign out_valid = main_v_q;
  assign out_data  = main_q;

  pipe_stage_cnt_sat #(
    .W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .en_i  (main_v_q && !out_ready && !flush),
    .cnt_o (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed scoreboard bench for pipe_stage_reg:
// skid, no-skid and narrow-counter variants.
module tb_pipe_stage_reg;

  localparam logic [7:0] BUB = 8'h80;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        in_valid, out_ready, flush;
  logic [7:0]  in_data;
  logic        in_ready, out_valid;
  logic [7:0]  out_data;
  logic [15:0] stall_cnt;

  logic        s_in_ready, s_out_valid;
  logic [7:0]  s_out_data;
  logic [3:0]  s_cnt;

  logic        z_iv, z_or, z_fl;
  logic [7:0]  z_d;
  logic        z_ir, z_ov;
  logic [7:0]  z_od;
  logic [15:0] z_cnt;

  int n_asrt = 0;
  int n_fail = 0;
  logic [7:0] sbq[$];

  pipe_stage_reg #(
    .PAYLOAD_W (8), .SKID (1'b1),
    .BUBBLE_VAL (BUB), .CNT_W (16)
  ) dut (
    .clk (clk), .reset (reset),
    .in_valid (in_valid), .in_ready (in_ready),
    .in_data (in_data), .out_valid (out_valid),
    .out_ready (out_ready), .out_data (out_data),
    .flush (flush), .stall_cnt (stall_cnt)
  );

  pipe_stage_reg #(
    .PAYLOAD_W (8), .SKID (1'b1),
    .BUBBLE_VAL (BUB), .CNT_W (4)
  ) u_sat (
    .clk (clk), .reset (reset),
    .in_valid (in_valid), .in_ready (s_in_ready),
    .in_data (in_data), .out_valid (s_out_valid),
    .out_ready (out_ready), .out_data (s_out_data),
    .flush (flush), .stall_cnt (s_cnt)
  );

  pipe_stage_reg #(
    .PAYLOAD_W (8), .SKID (1'b0),
    .BUBBLE_VAL (BUB), .CNT_W (16)
  ) u_ns (
    .clk (clk), .reset (reset),
    .in_valid (z_iv), .in_ready (z_ir),
    .in_data (z_d), .out_valid (z_ov),
    .out_ready (z_or), .out_data (z_od),
    .flush (z_fl), .stall_cnt (z_cnt)
  );

  task automatic chk_b(input string tag,
                       input logic obs, input logic exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_d(input string tag,
                       input logic [7:0] obs,
                       input logic [7:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_c(input string tag,
                       input logic [15:0] obs,
                       input logic [15:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle; score the deliver and accept of that edge.
  task automatic step(input logic v, input logic [7:0] d,
                      input logic r, input logic f);
    logic [7:0] e;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
    #1;
    if (out_valid && out_ready) begin
      n_asrt++;
      assert (sbq.size() != 0) else begin
        n_fail++;
        $error("FAIL sb_spurious observed=%h expected=none",
               out_data);
      end
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        chk_d("sb_data", out_data, e);
      end
    end
    if (f) sbq.delete();
    else if (in_valid && in_ready) sbq.push_back(in_data);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'hA5;
    out_ready = 1'b1;
    flush     = 1'b0;
    z_iv = 1'b0; z_d = 8'h00; z_or = 1'b1; z_fl = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_b("rst_valid", out_valid, 1'b0);
    chk_d("rst_data", out_data, BUB);
    chk_c("rst_cnt", stall_cnt, 16'd0);
    chk_b("rst_rdy", in_ready, 1'b1);
    chk_b("rst_ns_valid", z_ov, 1'b0);
    reset = 1'b1;

    step(1'b1, 8'hA5, 1'b1, 1'b0);
    chk_b("lat_valid", out_valid, 1'b1);
    chk_d("lat_data", out_data, 8'hA5);

    for (int i = 1; i <= 8; i++) begin
      chk_b("stream_rdy", in_ready, 1'b1);
      step(1'b1, 8'(i), 1'b1, 1'b0);
      chk_d("stream_out", out_data, 8'(i));
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk_b("drain_valid", out_valid, 1'b0);
    chk_c("drain_sb", 16'(sbq.size()), 16'd0);

    step(1'b1, 8'h11, 1'b0, 1'b0);
    chk_b("bp_rdy1", in_ready, 1'b1);
    step(1'b1, 8'h22, 1'b0, 1'b0);
    chk_b("bp_rdy2", in_ready, 1'b0);
    step(1'b1, 8'h33, 1'b0, 1'b0);
    step(1'b1, 8'h33, 1'b0, 1'b0);
    chk_d("bp_hold", out_data, 8'h11);
    chk_c("bp_cnt", stall_cnt, 16'd3);
    step(1'b1, 8'h33, 1'b1, 1'b0);
    chk_b("bp_rdy3", in_ready, 1'b1);
    step(1'b1, 8'h33, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk_c("bp_sb", 16'(sbq.size()), 16'd0);
    chk_c("bp_cnt_end", stall_cnt, 16'd3);
    chk_c("bp_sat_cnt", {12'd0, s_cnt}, 16'd3);

    step(1'b1, 8'h11, 1'b0, 1'b0);
    step(1'b1, 8'h22, 1'b0, 1'b0);
    step(1'b1, 8'h44, 1'b0, 1'b1);
    chk_b("fl_valid", out_valid, 1'b0);
    chk_d("fl_data", out_data, BUB);
    chk_b("fl_rdy", in_ready, 1'b1);
    chk_c("fl_cnt", stall_cnt, 16'd4);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk_b("fl_no44", out_valid, 1'b0);

    step(1'b1, 8'h55, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    chk_b("fl_dlv_valid", out_valid, 1'b0);

    step(1'b1, 8'h66, 1'b0, 1'b0);
    repeat (20) step(1'b0, 8'h00, 1'b0, 1'b0);
    chk_c("sat_15", {12'd0, s_cnt}, 16'd15);
    repeat (2) step(1'b0, 8'h00, 1'b0, 1'b0);
    chk_c("sat_hold", {12'd0, s_cnt}, 16'd15);
    chk_c("wide_cnt", stall_cnt, 16'd26);
    chk_d("sat_data", out_data, 8'h66);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    step(1'b1, 8'h77, 1'b0, 1'b0);
    reset = 1'b0;
    #1;
    chk_b("mid_rst_valid", out_valid, 1'b0);
    chk_d("mid_rst_data", out_data, BUB);
    chk_c("mid_rst_cnt", stall_cnt, 16'd0);
    chk_c("mid_rst_sat", {12'd0, s_cnt}, 16'd0);
    sbq.delete();
    @(posedge clk);
    #1;
    reset = 1'b1;
    step(1'b1, 8'h88, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk_c("end_sb", 16'(sbq.size()), 16'd0);

    z_iv = 1'b1; z_d = 8'h21; z_or = 1'b0;
    @(posedge clk);
    #1;
    chk_b("ns_valid", z_ov, 1'b1);
    chk_d("ns_data", z_od, 8'h21);
    chk_b("ns_rdy_lo", z_ir, 1'b0);
    z_or = 1'b1;
    z_d  = 8'h42;
    #1;
    chk_b("ns_rdy_hi", z_ir, 1'b1);
    @(posedge clk);
    #1;
    chk_b("ns_pass_valid", z_ov, 1'b1);
    chk_d("ns_pass_data", z_od, 8'h42);
    z_iv = 1'b0;
    @(posedge clk);
    #1;
    chk_b("ns_empty", z_ov, 1'b0);
    chk_d("ns_bubble", z_od, BUB);
    chk_c("ns_cnt", z_cnt, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asrt, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic, parametrised pipeline stage register that replaces the fixed per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one block.
- Carries an opaque payload bundle with a valid/ready handshake, stall back-pressure, synchronous flush and an optional one-entry skid buffer.
- Each stage instantiates it with its own payload width and bubble pattern.
- Provides a saturating stall-cycle counter for performance monitoring.

Parameters:
- PAYLOAD_W, 128: payload width in bits (e.g. pc+insn+alu_out+gpr_we_+dst_addr+mem data, packed by the instantiating stage).
- SKID, 1: 1 = two-entry (main + skid) with fully registered in_ready; 0 = single register with combinational in_ready.
- BUBBLE_VAL, {PAYLOAD_W{1'b0}}: payload driven when out_valid=0. The stage sets its active-low gpr_we_ bit to 1 here, so a bubble never writes the GPR.
- CNT_W, 16: stall counter width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream holds valid payload.
- in_ready  out  1  stage can accept this cycle.
- in_data  in  PAYLOAD_W  upstream payload.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts this cycle.
- out_data  out  PAYLOAD_W  registered payload.
- flush  in  1  synchronous kill of all held entries (branch/trap redirect).
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0; saturating.

Behaviour:
- Reset (async assert, sync-to-clk release is the system's job):
  - out_valid=0, out_data=BUBBLE_VAL, skid empty, stall_cnt=0.
  - in_ready=1 when SKID=1.
  - Reset mid-transfer discards all entries.
- Handshakes:
  - Accept when in_valid&&in_ready at a posedge.
  - Deliver when out_valid&&out_ready at a posedge.
  - out_valid/out_data stay stable while out_valid&&!out_ready.
- Latency: 1 cycle from accept to out_valid (empty stage). Throughput is 1/cycle with out_ready held high.
- SKID=0:
  - in_ready = out_ready || !out_valid (combinational).
  - Main register loads on accept; otherwise clears to bubble on deliver.
- SKID=1 state machine, encoded by {skid_v, main_v}:
  - EMPTY:
    - accept -> BUSY (main<=in_data).
  - BUSY:
    - accept&&deliver -> BUSY (main<=in_data).
    - accept&&!deliver -> FULL (skid<=in_data).
    - !accept&&deliver -> EMPTY (main<=BUBBLE_VAL).
    - Otherwise hold.
  - FULL (in_ready=0):
    - deliver -> BUSY (main<=skid, skid cleared).
    - Otherwise hold.
  - in_ready = !skid_v, which is a registered signal.
  - Ordering is strictly FIFO; the skid entry never overtakes main.
- flush:
  - Dominates accept and deliver in the same cycle.
  - Next cycle: out_valid=0, out_data=BUBBLE_VAL, skid empty (EMPTY), in_ready=1.
  - An in_data presented during the flush cycle is dropped.
  - A deliver in the flush cycle still counts as consumed downstream; the stage does not re-present it.
- stall_cnt:
  - Increments by 1 each posedge with out_valid&&!out_ready&&!flush.
  - Saturates at 2^CNT_W-1 with no wrap.
  - Cleared only by reset.
- The stage never modifies the payload bits; it only substitutes BUBBLE_VAL when out_valid=0.

Decomposition:
- Shared package/define file holds:
  - Per-stage payload widths and field offsets (PC, INSN, ALU_OUT, GPR_WE_, DST_ADDR, MEM_DATA).
  - Per-stage bubble constants.
  - The SKID state encodings.
- Natural sub-module: pipe_stage_cnt_sat, a saturating CNT_W counter with enable.

Test Plan:
- Reset: hold reset=0 with in_valid=1, in_data=0xA5 -> out_valid=0, out_data=BUBBLE_VAL, stall_cnt=0. After release, the first accept produces out_data=0xA5 one cycle later.
- Streaming (SKID=1, out_ready=1): send payloads 1..8 on consecutive cycles -> out_data sequence 1..8, one per cycle, 1-cycle latency, in_ready constantly 1.
- Back-pressure: out_ready=0 while sending 0x11, 0x22, 0x33:
  - out_data holds 0x11 and in_ready drops after 0x22 is accepted; 0x33 waits.
  - out_ready=1 releases 0x11, 0x22, 0x33 in order; stall_cnt equals the number of held cycles.
- Flush in FULL (main=0x11, skid=0x22) with in_valid=1, in_data=0x44 -> next cycle out_valid=0, out_data=BUBBLE_VAL, in_ready=1; 0x44 is never delivered.
- Saturation with CNT_W=4: hold a stall for 20 cycles -> stall_cnt=15 and stays at 15.
- SKID=0: out_ready=0 with out_valid=1 -> in_ready=0 in the same cycle; toggle out_ready=1 -> in_ready=1 combinationally, and accept+deliver occur in the same cycle.
